// File: rtl/apb_master_bridge_pkg.sv
// apb_bridge_pkg: shared types for the valid/ready to APB master bridge.
// FSM states, transfer/protection enums, request/response bundles, widths.
package apb_bridge_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int STRB_W   = DATA_W / 8;
  localparam int SLV_ID_W = 4;
  localparam int WAIT_W   = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    WAIT_STATE,
    RESP
  } state_e;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } tx_type_e;

  // bit0 privileged, bit1 non-secure, bit2 instruction
  typedef enum logic [2:0] {
    PROT_NORMAL          = 3'b000,
    PROT_PRIV            = 3'b001,
    PROT_NSEC            = 3'b010,
    PROT_PRIV_NSEC       = 3'b011,
    PROT_INSTR           = 3'b100,
    PROT_PRIV_INSTR      = 3'b101,
    PROT_NSEC_INSTR      = 3'b110,
    PROT_PRIV_NSEC_INSTR = 3'b111
  } protection_type_e;

  typedef struct packed {
    tx_type_e              write;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [STRB_W-1:0]     strb;
    protection_type_e      prot;
    logic [SLV_ID_W-1:0]   slave_id;
  } req_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              slverr;
    logic [WAIT_W-1:0] wait_states;
  } rsp_t;

  function automatic logic [WAIT_W-1:0] sat_inc(
    input logic [WAIT_W-1:0] v
  );
    return (&v) ? v : v + WAIT_W'(1);
  endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: request/response handshake plus APB bus signals.
// master = bridge side (drives APB, req_ready, rsp_*); slave = environment.
interface apb_master_bridge_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NO_OF_SLAVES  = 1
);

  logic                       req_valid;
  logic                       req_ready;
  logic                       req_write;
  logic [ADDRESS_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]      req_wdata;
  logic [DATA_WIDTH/8-1:0]    req_strb;
  logic [2:0]                 req_prot;
  logic [3:0]                 req_slave_id;

  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [DATA_WIDTH-1:0]      rsp_rdata;
  logic                       rsp_slverr;
  logic [15:0]                rsp_wait_states;

  logic [ADDRESS_WIDTH-1:0]   paddr;
  logic [NO_OF_SLAVES-1:0]    psel;
  logic                       penable;
  logic                       pwrite;
  logic [DATA_WIDTH-1:0]      pwdata;
  logic [DATA_WIDTH/8-1:0]    pstrb;
  logic [2:0]                 pprot;
  logic [DATA_WIDTH-1:0]      prdata;
  logic                       pready;
  logic                       pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  req_strb, req_prot, req_slave_id,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_slverr, rsp_wait_states,
    input  rsp_ready,
    output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output req_strb, req_prot, req_slave_id,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_slverr, rsp_wait_states,
    output rsp_ready,
    input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready request -> APB SETUP/ACCESS transfer -> response.
// Ports: pclk, preset_n (async, active low), bus (apb_master_bridge_if.master).
// Optional macro APB_TIMEOUT_EN: abort after TIMEOUT_CYCLES wait states.
module apb_master_bridge
  import apb_bridge_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = ADDR_W,
  parameter int DATA_WIDTH     = DATA_W,
  parameter int NO_OF_SLAVES   = 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                 pclk,
  input logic                 preset_n,
  apb_master_bridge_if.master bus
);

`ifdef APB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  localparam logic [WAIT_W-1:0] TIMEOUT_LIMIT =
    WAIT_W'(TIMEOUT_CYCLES);

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  rsp_t              rsp_q, rsp_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              sel_q, sel_d;
  logic              penable_q, penable_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              id_ok;
  logic [NO_OF_SLAVES-1:0] psel_vec;

  assign id_ok = int'(bus.req_slave_id) < NO_OF_SLAVES;

  // psel decoded from the latched id; sel_q gates it to SETUP/ACCESS
  always_comb begin
    psel_vec = '0;
    for (int i = 0; i < NO_OF_SLAVES; i++)
      psel_vec[i] = sel_q && (int'(req_q.slave_id) == i);
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rsp_d       = rsp_q;
    wait_d      = wait_q;
    sel_d       = sel_q;
    penable_d   = penable_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        // req_ready_q is low for the first cycle out of reset
        if (bus.req_valid && req_ready_q) begin
          req_ready_d    = 1'b0;
          req_d.write    = tx_type_e'(bus.req_write);
          req_d.addr     = ADDR_W'(bus.req_addr);
          req_d.wdata    = bus.req_write ?
                           DATA_W'(bus.req_wdata) : '0;
          req_d.strb     = bus.req_write ?
                           STRB_W'(bus.req_strb) : '0;
          req_d.prot     = protection_type_e'(bus.req_prot);
          req_d.slave_id = bus.req_slave_id;
          wait_d         = '0;
          if (id_ok) begin
            state_d   = SETUP;
            sel_d     = 1'b1;
            penable_d = 1'b0;
          end else begin
            // decode error: answer directly, no APB cycle
            state_d           = RESP;
            rsp_valid_d       = 1'b1;
            rsp_d.rdata       = '0;
            rsp_d.slverr      = 1'b1;
            rsp_d.wait_states = '0;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS, WAIT_STATE: begin
        if (bus.pready) begin
          state_d           = RESP;
          sel_d             = 1'b0;
          penable_d         = 1'b0;
          rsp_valid_d       = 1'b1;
          rsp_d.rdata       = (req_q.write == WRITE) ?
                              '0 : DATA_W'(bus.prdata);
          rsp_d.slverr      = bus.pslverr;
          rsp_d.wait_states = wait_q;
        end else if (TIMEOUT_ON &&
                     state_q == WAIT_STATE &&
                     wait_q >= TIMEOUT_LIMIT) begin
          state_d           = RESP;
          sel_d             = 1'b0;
          penable_d         = 1'b0;
          rsp_valid_d       = 1'b1;
          rsp_d.rdata       = '0;
          rsp_d.slverr      = 1'b1;
          rsp_d.wait_states = TIMEOUT_LIMIT;
        end else begin
          state_d = WAIT_STATE;
          wait_d  = sat_inc(wait_q);
        end
      end
      RESP: begin
        rsp_valid_d = 1'b1;
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        sel_d     = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      rsp_q       <= '0;
      wait_q      <= '0;
      sel_q       <= 1'b0;
      penable_q   <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      rsp_q       <= rsp_d;
      wait_q      <= wait_d;
      sel_q       <= sel_d;
      penable_q   <= penable_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.req_ready       = req_ready_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_rdata       = rsp_q.rdata[DATA_WIDTH-1:0];
  assign bus.rsp_slverr      = rsp_q.slverr;
  assign bus.rsp_wait_states = rsp_q.wait_states;

  assign bus.paddr   = req_q.addr[ADDRESS_WIDTH-1:0];
  assign bus.psel    = psel_vec;
  assign bus.penable = penable_q;
  assign bus.pwrite  = req_q.write;
  assign bus.pwdata  = req_q.wdata[DATA_WIDTH-1:0];
  assign bus.pstrb   = req_q.strb[DATA_WIDTH/8-1:0];
  assign bus.pprot   = req_q.prot;

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Converts a simple valid/ready request/response interface into APB protocol transfers (IDLE -> SETUP -> ACCESS, with wait states) toward the SPI master's APB slave port.
- Sits directly upstream of the APB slave. It is the RTL counterpart of the APB master agent: it drives paddr/psel/penable/pwrite/pwdata/pstrb/pprot and consumes prdata/pready/pslverr.
- Returns read data, slave error and the observed wait-state count per transfer.

Parameters:
- ADDRESS_WIDTH, 32, width of paddr/req_addr.
- DATA_WIDTH, 32, width of pwdata/prdata/req_wdata/rsp_rdata; must be a multiple of 8.
- NO_OF_SLAVES, 1, number of one-hot psel lines (1..16).
- TIMEOUT_CYCLES, 256, wait-state limit (used only with APB_TIMEOUT_EN).

Ports:
- pclk  in  1  APB clock; all logic on rising edge.
- preset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  bridge accepts request this cycle.
- req_write  in  1  1=WRITE, 0=READ.
- req_addr  in  ADDRESS_WIDTH  transfer address.
- req_wdata  in  DATA_WIDTH  write data.
- req_strb  in  DATA_WIDTH/8  write byte strobes.
- req_prot  in  3  protection type.
- req_slave_id  in  4  target slave index.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_slverr  out  1  slave error, decode error or timeout.
- rsp_wait_states  out  16  wait cycles observed, saturating at 16'hFFFF.
- paddr  out  ADDRESS_WIDTH.
- psel  out  NO_OF_SLAVES  one-hot.
- penable  out  1.
- pwrite  out  1.
- pwdata  out  DATA_WIDTH.
- pstrb  out  DATA_WIDTH/8.
- pprot  out  3.
- prdata  in  DATA_WIDTH.
- pready  in  1.
- pslverr  in  1.

Behaviour:
- Reset (async, preset_n=0): FSM=IDLE; every output 0 (psel, penable, req_ready, rsp_* and all APB address/data/control outputs); wait counter cleared. Effect is immediate, including mid-transfer, with no completion. req_ready rises in the first cycle after reset release.
- FSM states, in package enum: IDLE, SETUP, ACCESS, WAIT_STATE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: register addr/wdata/strb/prot/write.
  - If req_slave_id < NO_OF_SLAVES: go to SETUP.
  - Otherwise: go to RESP with rsp_slverr=1, rdata=0, wait=0, and no APB activity.
- SETUP: psel[id]=1, penable=0, APB outputs stable. Next state ACCESS unconditionally.
- ACCESS / WAIT_STATE: psel and penable both 1; all APB outputs held stable.
  - pready=1: capture prdata (reads only), pslverr and wait count; drop psel/penable; go to RESP.
  - pready=0: increment wait count (saturating); go to or stay in WAIT_STATE.
- RESP: rsp_valid=1 and response fields held until rsp_ready=1, then go to IDLE. rsp_valid falls the cycle after the handshake.
- req_ready=0 in every state except IDLE. Minimum request-to-request spacing is 4 cycles (0-wait transfer with rsp_ready tied high).
- Transfer latency: request accept -> rsp_valid = 3 cycles + wait states.
- pready and pslverr are ignored outside ACCESS/WAIT_STATE.
- pwdata and pstrb are driven 0 on reads; prdata is ignored on writes.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined: when the wait count reaches TIMEOUT_CYCLES in WAIT_STATE, abort. Drop psel/penable, go to RESP with rsp_slverr=1, rsp_rdata=0, rsp_wait_states=TIMEOUT_CYCLES.
- Undefined: no timeout; the bridge waits indefinitely for pready.

Decomposition:
- Shared package apb_bridge_pkg:
  - FSM state enum.
  - tx_type_e (WRITE=1/READ=0).
  - protection_type_e.
  - Request struct {write, addr, wdata, strb, prot, slave_id}.
  - Response struct {rdata, slverr, wait_states}.
  - Width parameters.
- Sub-module: none. A single module is natural; the wait counter is a few lines.

Test Plan:
- 0-wait write: addr=32'h1A10_2000, wdata=32'hDEAD_BEEF, strb=4'hF, slave 0 -> SETUP then ACCESS one cycle each; rsp_valid 3 cycles after accept; slverr=0, wait_states=0, rdata=0.
- Read with 3 wait states: pready low for 3 ACCESS cycles, prdata=32'h0000_00A5 -> rsp_rdata=32'hA5, wait_states=3, APB outputs stable throughout.
- pslverr=1 with pready on read -> rsp_slverr=1; next request accepted after rsp_ready.
- Decode error: req_slave_id=4'd3 with NO_OF_SLAVES=1 -> psel never asserts; rsp_slverr=1 one cycle after accept.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_* held constant, req_ready=0, no new SETUP.
- Reset mid-WAIT_STATE: preset_n low -> psel/penable/rsp_valid 0 immediately. With APB_TIMEOUT_EN and TIMEOUT_CYCLES=8, pready never high -> rsp_slverr=1, wait_states=8.
